if_id_elastic_reg: RTL and testbench

//  - Parametrised IF/ID pipeline register. Successor to the fixed 32-bit IF/ID latch.
//  - Adds a valid/ready handshake, a 2-entry skid buffer so in_ready is fully registered,
//    and a synchronous flush for branch/jump squash.
//  - Sits between the fetch unit (upstream) and the decode stage (downstream).

---
 rtl/mips_pipe_pkg.sv | 11 +
 rtl/pipe_skid_buf.sv | 60 ++++++
 rtl/if_id_elastic_reg.sv | 55 +++++
 tb/tb_if_id_elastic_reg.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared IF/ID widths, NOP encoding, payload struct and elastic-stage states
package mips_pipe_pkg;
  localparam int DEFAULT_INSTR_W = 32;
  localparam int DEFAULT_PC_W = 32;
  localparam logic [DEFAULT_INSTR_W-1:0] DEFAULT_NOP_INSTR = '0;
  typedef struct packed {
    logic [DEFAULT_INSTR_W-1:0] instr;
    logic [DEFAULT_PC_W-1:0]    pc4;
  } if_id_payload_t;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} elastic_state_e;
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: 2-entry skid buffer (main + skid slot) with registered in_ready and sync flush
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  elastic_state_e state_q, state_d;
  logic [W-1:0] m_q, m_d, s_q, s_d;
  logic in_fire, out_fire;
  assign in_ready_o  = state_q != SKID;
  assign out_valid_o = state_q != EMPTY;
  assign out_data_o  = m_q;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  // next state: flush empties everything; data slots only load on a fire
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    s_d = s_q;
    if (flush_i) state_d = EMPTY;
    else case (state_q)
      EMPTY: if (in_fire) begin
        state_d = FULL;
        m_d = in_data_i;
      end
      FULL: if (in_fire && out_fire) m_d = in_data_i;
      else if (in_fire) begin
        state_d = SKID;
        s_d = in_data_i;
      end
      else if (out_fire) state_d = EMPTY;
      default: if (out_fire) begin
        state_d = FULL;
        m_d = s_q;
      end
    endcase
  end
  // state and slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q <= '0;
      s_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      s_q <= s_d;
    end
  end
endmodule

// File: rtl/if_id_elastic_reg.sv
// if_id_elastic_reg: elastic IF/ID register with NOP substitution; IF_ID_PERF_CNT_EN adds stall/flush counters
module if_id_elastic_reg
  import mips_pipe_pkg::*;
#(
  parameter int INSTR_W = DEFAULT_INSTR_W,
  parameter int PC_W = DEFAULT_PC_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc4
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);
  logic [INSTR_W+PC_W-1:0] out_data;
  pipe_skid_buf #(.W(INSTR_W + PC_W)) u_buf (
    .clk        (clk),
    .rst        (reset),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  ({in_instr, in_pc4}),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data)
  );
  assign out_instr = out_valid ? out_data[PC_W +: INSTR_W] : NOP_INSTR;
  assign out_pc4   = out_valid ? out_data[PC_W-1:0] : '0;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  // count decode stalls and flushes that squash a non-empty stage
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && out_valid) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_elastic_reg.sv
// tb_if_id_elastic_reg: directed and random self-checking bench for if_id_elastic_reg
module tb_if_id_elastic_reg;
  import mips_pipe_pkg::*;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc4 = 0, out_instr, out_pc4;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif
  int n_cmp = 0, n_err = 0;
  if_id_payload_t q[$];
  if_id_payload_t p;
  always #5 clk = ~clk;
  if_id_elastic_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_instr"}, out_instr, ins);
    chk({tag, ".out_pc4"}, out_pc4, pc);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
  endtask
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic ordy, input logic fl);
    in_valid = v;
    in_instr = ins;
    in_pc4 = pc;
    out_ready = ordy;
    flush = fl;
  endtask
  initial begin
    tick();
    tick();
    reset = 0;
    tick();
    chk_out("reset_idle", 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h20080001 + i, 32'(4 * (i + 1)), 1, 0);
      tick();
      chk_out($sformatf("stream%0d", i), 1, 32'h20080001 + i, 32'(4 * (i + 1)), 1);
    end
    drive(0, 0, 0, 1, 0);
    tick();
    chk_out("stream_end", 0, 0, 0, 1);
    drive(1, 32'hA0, 32'h100, 1, 0);
    tick();
    chk_out("bp_a0", 1, 32'hA0, 32'h100, 1);
    drive(1, 32'hA1, 32'h104, 0, 0);
    tick();
    chk_out("bp_stall1", 1, 32'hA0, 32'h100, 0);
    drive(1, 32'hA2, 32'h108, 0, 0);
    tick();
    chk_out("bp_stall2", 1, 32'hA0, 32'h100, 0);
    tick();
    chk_out("bp_stall3", 1, 32'hA0, 32'h100, 0);
    drive(1, 32'hA2, 32'h108, 1, 0);
    tick();
    chk_out("bp_drain_a1", 1, 32'hA1, 32'h104, 1);
    tick();
    chk_out("bp_drain_a2", 1, 32'hA2, 32'h108, 1);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_out("bp_empty", 0, 0, 0, 1);
    drive(1, 32'hB0, 32'h200, 0, 0);
    tick();
    drive(1, 32'hB1, 32'h204, 0, 0);
    tick();
    chk_out("skid_fill", 1, 32'hB0, 32'h200, 0);
    drive(1, 32'h8C090004, 32'h208, 0, 1);
    tick();
    chk_out("flush_skid", 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_out("flush_skid_after", 0, 0, 0, 1);
    drive(1, 32'hC0, 32'h300, 0, 0);
    tick();
    drive(1, 32'h8C090004, 32'h304, 1, 1);
    tick();
    chk_out("flush_full_fire", 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    tick();
    chk_out("flush_full_after", 0, 0, 0, 1);
    drive(1, 32'hD0, 32'h400, 0, 0);
    tick();
    drive(1, 32'hD1, 32'h404, 0, 0);
    tick();
    chk_out("pre_reset_skid", 1, 32'hD0, 32'h400, 0);
    reset = 1;
    drive(1, 32'hD2, 32'h408, 1, 0);
    tick();
    chk_out("reset_mid1", 0, 0, 0, 1);
    tick();
    chk_out("reset_mid2", 0, 0, 0, 1);
    reset = 0;
    drive(0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 10000; c++) begin
      drive(($urandom & 3) != 0, $urandom, $urandom, ($urandom & 3) != 0, ($urandom & 31) == 0);
      p.instr = in_instr;
      p.pc4 = in_pc4;
      if (flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && q.size() + ((q.size() > 0 && out_ready) ? 1 : 0) < 2) q.push_back(p);
      end
      tick();
      chk("rnd.in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd.out_instr", out_instr, q.size() > 0 ? q[0].instr : 32'h0);
      chk("rnd.out_pc4", out_pc4, q.size() > 0 ? q[0].pc4 : 32'h0);
    end
`ifdef IF_ID_PERF_CNT_EN
    reset = 1;
    drive(0, 0, 0, 0, 0);
    tick();
    reset = 0;
    chk("perf.stall_rst", stall_cnt, 0);
    chk("perf.flush_rst", flush_cnt, 0);
    drive(1, 32'hE0, 32'h500, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (5) tick();
    drive(0, 0, 0, 1, 1);
    tick();
    drive(1, 32'hE1, 32'h504, 1, 0);
    tick();
    drive(0, 0, 0, 1, 1);
    tick();
    tick();
    chk("perf.stall_cnt", stall_cnt, 5);
    chk("perf.flush_cnt", flush_cnt, 2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
